// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: FSM encoding, header size,
// synchronizer depth and SPI-mode edge selection.
package spi_pkg;

  localparam int unsigned HDR_BITS    = 16;
  localparam int unsigned HDR_CNT_W   = $clog2(HDR_BITS);
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MS_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XCHG = 2'd2
  } state_t;

  // Leading edge is rising when CPOL=0; CPHA=0 samples on the leading edge.
  // Hence sampling happens on the rising SCK edge exactly when CPOL == CPHA.
  function automatic logic sample_on_rise(input int unsigned cpol, input int unsigned cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with rise/fall detection.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level (registered)
//   rise_c     : 1-cycle pulse when the synchronized level goes 0->1
//   fall_c     : 1-cycle pulse when the synchronized level goes 1->0
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level  = sync[STAGES-1];
  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/spi_peripheral_sync.sv
// Oversampled SPI peripheral: 16-bit bit-index header, then full-duplex
// exchange at decrementing (wrapping) bit indices of a user record.
// Ports:
//   sysclock, sysreset_n : system clock, async active-low reset
//   device_clk/ss/copi   : asynchronous SPI pins (SS active-low)
//   device_cipo          : SPI CIPO, high-Z while device_ss is high
//   copi_data            : record written by the controller
//   cipo_data            : record read by the controller (snapshotted per frame)
//   busy                 : high while exchanging data
//   rx_done              : pulse at end of a frame that carried data bits
//   frame_error          : pulse when SS rises during the header
//   wdog_alarm           : no frame started within WDOG_TIMEOUT ms
module spi_peripheral_sync
  import spi_pkg::*;
#(
  parameter int unsigned SYSCLK_MHZ   = 27,
  parameter int unsigned WDOG_TIMEOUT = 2000,
  parameter int unsigned REC_BYTES    = 256,
  parameter int unsigned CPOL         = 0,
  parameter int unsigned CPHA         = 0
) (
  input  logic                   sysclock,
  input  logic                   sysreset_n,
  input  logic                   device_clk,
  input  logic                   device_ss,
  input  logic                   device_copi,
  output logic                   device_cipo,
  output logic [8*REC_BYTES-1:0] copi_data,
  input  logic [8*REC_BYTES-1:0] cipo_data,
  output logic                   busy,
  output logic                   rx_done,
  output logic                   frame_error,
  output logic                   wdog_alarm
);

  localparam int unsigned REC_BITS    = 8 * REC_BYTES;
  localparam int unsigned IDX_W       = (REC_BITS > 8) ? $clog2(REC_BITS) : 3;
  localparam logic        SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam int unsigned PRESC_CYC   = SYSCLK_MHZ * 1000;
  localparam int unsigned PRESC_W     = (PRESC_CYC > 1) ? $clog2(PRESC_CYC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_CYC - 1);
  localparam logic        WDOG_EN     = (WDOG_TIMEOUT != 0);

  // Pin synchronizers. SS resets low so an SS held low across reset release
  // produces no falling edge; a fresh assertion is required.
  logic sck_level_unused, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic copi_level, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sync_sck (
    .clk    (sysclock),
    .rst_n  (sysreset_n),
    .din    (device_clk),
    .level  (sck_level_unused),
    .rise_c (sck_rise),
    .fall_c (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
    .clk    (sysclock),
    .rst_n  (sysreset_n),
    .din    (device_ss),
    .level  (ss_level),
    .rise_c (ss_rise),
    .fall_c (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk    (sysclock),
    .rst_n  (sysreset_n),
    .din    (device_copi),
    .level  (copi_level),
    .rise_c (copi_rise_unused),
    .fall_c (copi_fall_unused)
  );

  logic sample_c, launch_c;
  assign sample_c = SAMPLE_RISE ? sck_rise : sck_fall;
  assign launch_c = SAMPLE_RISE ? sck_fall : sck_rise;

  // Frame state
  state_t                state_q, state_n;
  logic [HDR_BITS-1:0]   hdr_q, hdr_n;
  logic [HDR_CNT_W-1:0]  hdr_cnt_q, hdr_cnt_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic                  got_data_q, got_data_n;
  logic                  cipo_q, cipo_n;
  logic [REC_BITS-1:0]   snap_q, snap_n;
  logic [REC_BITS-1:0]   copi_data_n;
  logic                  busy_n, rx_done_n, frame_error_n;

  // Next-state logic; an SS rise always takes priority over a same-cycle sample.
  always_comb begin
    state_n       = state_q;
    hdr_n         = hdr_q;
    hdr_cnt_n     = hdr_cnt_q;
    idx_n         = idx_q;
    got_data_n    = got_data_q;
    cipo_n        = cipo_q;
    snap_n        = snap_q;
    copi_data_n   = copi_data;
    rx_done_n     = 1'b0;
    frame_error_n = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_n    = ST_HDR;
          snap_n     = cipo_data;
          hdr_n      = '0;
          hdr_cnt_n  = HDR_CNT_W'(HDR_BITS - 1);
          idx_n      = '0;
          got_data_n = 1'b0;
          cipo_n     = 1'b0;
        end
      end
      ST_HDR: begin
        if (ss_rise) begin
          state_n       = ST_IDLE;
          frame_error_n = 1'b1;
        end else begin
          if (sample_c) begin
            hdr_n = {hdr_q[HDR_BITS-2:0], copi_level};
            if (hdr_cnt_q == '0) begin
              idx_n   = hdr_n[IDX_W-1:0];
              state_n = ST_XCHG;
            end else begin
              hdr_cnt_n = hdr_cnt_q - HDR_CNT_W'(1);
            end
          end
          // hdr_q[0] is the latest sampled COPI bit (0 before the first one).
          if (launch_c) begin
            cipo_n = hdr_q[0];
          end
        end
      end
      ST_XCHG: begin
        if (ss_rise) begin
          state_n   = ST_IDLE;
          rx_done_n = got_data_q;
        end else begin
          if (sample_c) begin
            copi_data_n[idx_q] = copi_level;
            idx_n              = idx_q - IDX_W'(1);
            got_data_n         = 1'b1;
          end
          if (launch_c) begin
            cipo_n = snap_q[idx_q];
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n == ST_XCHG);
  end

  // Frame state registers
  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      hdr_cnt_q   <= '0;
      idx_q       <= '0;
      got_data_q  <= 1'b0;
      cipo_q      <= 1'b0;
      snap_q      <= '0;
      copi_data   <= '0;
      busy        <= 1'b0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_n;
      hdr_q       <= hdr_n;
      hdr_cnt_q   <= hdr_cnt_n;
      idx_q       <= idx_n;
      got_data_q  <= got_data_n;
      cipo_q      <= cipo_n;
      snap_q      <= snap_n;
      copi_data   <= copi_data_n;
      busy        <= busy_n;
      rx_done     <= rx_done_n;
      frame_error <= frame_error_n;
    end
  end

  assign device_cipo = device_ss ? 1'bz : cipo_q;

  // Link watchdog: ms prescaler and saturating ms counter, run while SS is high.
  logic [PRESC_W-1:0]  presc;
  logic [MS_CNT_W-1:0] ms_cnt, ms_next;

  always_comb begin
    ms_next = ms_cnt;
    if ((presc == PRESC_LAST) && (ms_cnt != {MS_CNT_W{1'b1}})) begin
      ms_next = ms_cnt + MS_CNT_W'(1);
    end
  end

  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      presc      <= '0;
      ms_cnt     <= '0;
      wdog_alarm <= 1'b0;
    end else if (!ss_level) begin
      presc      <= '0;
      ms_cnt     <= '0;
      wdog_alarm <= 1'b0;
    end else begin
      presc      <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      ms_cnt     <= ms_next;
      wdog_alarm <= WDOG_EN && (32'(ms_next) >= WDOG_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_spi_peripheral_sync.sv
// Directed bench for spi_peripheral_sync: one mode-0 and one mode-3 instance
// with a 4-byte record and a 2 ms watchdog at 1 MHz sysclock.
module tb_spi_peripheral_sync;

  localparam int HALF = 6;

  logic        clk, rst_n;
  logic        sck0, ss0, copi0, cipo0, busy0, rxd0, ferr0, alarm0;
  logic        sck3, ss3, copi3, cipo3, busy3, rxd3, ferr3, alarm3;
  logic [31:0] cdo0, cdi0, cdo3, cdi3;

  spi_peripheral_sync #(.SYSCLK_MHZ(1), .WDOG_TIMEOUT(2), .REC_BYTES(4), .CPOL(0), .CPHA(0)) d0 (
    .sysclock(clk), .sysreset_n(rst_n), .device_clk(sck0), .device_ss(ss0),
    .device_copi(copi0), .device_cipo(cipo0), .copi_data(cdo0), .cipo_data(cdi0),
    .busy(busy0), .rx_done(rxd0), .frame_error(ferr0), .wdog_alarm(alarm0)
  );

  spi_peripheral_sync #(.SYSCLK_MHZ(1), .WDOG_TIMEOUT(2), .REC_BYTES(4), .CPOL(1), .CPHA(1)) d3 (
    .sysclock(clk), .sysreset_n(rst_n), .device_clk(sck3), .device_ss(ss3),
    .device_copi(copi3), .device_cipo(cipo3), .copi_data(cdo3), .cipo_data(cdi3),
    .busy(busy3), .rx_done(rxd3), .frame_error(ferr3), .wdog_alarm(alarm3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse/cycle counters sampled away from the active edge.
  int rxd_cnt0 = 0, rxd_cnt3 = 0, ferr_cnt0 = 0, ferr_cnt3 = 0, busy_cnt0 = 0;
  always @(negedge clk) begin
    if (rxd0)  rxd_cnt0++;
    if (rxd3)  rxd_cnt3++;
    if (ferr0) ferr_cnt0++;
    if (ferr3) ferr_cnt3++;
    if (busy0) busy_cnt0++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin_sck(input int m, input logic v);
    if (m == 0) sck0 = v; else sck3 = v;
  endtask

  task automatic pin_ss(input int m, input logic v);
    if (m == 0) ss0 = v; else ss3 = v;
  endtask

  task automatic pin_copi(input int m, input logic v);
    if (m == 0) copi0 = v; else copi3 = v;
  endtask

  function automatic logic get_cipo(input int m);
    return (m == 0) ? cipo0 : cipo3;
  endfunction

  // Controller frame: n bits taken MSB-first from bits[47:...]; CIPO captured
  // on every rising SCK edge (the controller's sample edge in modes 0 and 3).
  task automatic frame(input int m, input logic [47:0] bits, input int n,
                       input bit raise, output logic [47:0] rx);
    rx = '0;
    pin_ss(m, 1'b0);
    pin_copi(m, bits[47]);
    wait_cyc(2 * HALF);
    for (int i = 0; i < n; i++) begin
      if (m == 0) begin
        pin_copi(m, bits[47-i]);
        wait_cyc(HALF);
        rx[47-i] = get_cipo(m);
        pin_sck(m, 1'b1);
        wait_cyc(HALF);
        pin_sck(m, 1'b0);
      end else begin
        pin_sck(m, 1'b0);
        pin_copi(m, bits[47-i]);
        wait_cyc(HALF);
        rx[47-i] = get_cipo(m);
        pin_sck(m, 1'b1);
        wait_cyc(HALF);
      end
    end
    wait_cyc(HALF);
    if (raise) begin
      pin_ss(m, 1'b1);
      wait_cyc(2 * HALF);
    end
  endtask

  initial begin
    logic [47:0] rx;
    int r0, f0, b0, r3;

    rst_n = 1'b0;
    sck0 = 1'b0; ss0 = 1'b1; copi0 = 1'b0; cdi0 = 32'h0;
    sck3 = 1'b1; ss3 = 1'b1; copi3 = 1'b0; cdi3 = 32'h0;
    wait_cyc(3);

    // Reset values
    chk("rst_copi_data", 64'(cdo0), 64'h0);
    chk("rst_busy", 64'(busy0), 64'h0);
    chk("rst_rx_done", 64'(rxd0), 64'h0);
    chk("rst_frame_error", 64'(ferr0), 64'h0);
    chk("rst_wdog_alarm", 64'(alarm0), 64'h0);

    // Watchdog with SS high from reset: alarm near 2000 sysclocks.
    rst_n = 1'b1;
    wait_cyc(1997);
    chk("wdog_early", 64'(alarm0), 64'h0);
    wait_cyc(7);
    chk("wdog_set", 64'(alarm0), 64'h1);

    // SS assertion clears the alarm within 3 cycles.
    pin_ss(0, 1'b0);
    wait_cyc(3);
    chk("wdog_clear", 64'(alarm0), 64'h0);

    // SS rises after 10 header bits.
    r0 = rxd_cnt0; f0 = ferr_cnt0; b0 = busy_cnt0;
    frame(0, {16'hABCD, 32'h0}, 10, 1'b1, rx);
    chk("abort_frame_error", 64'(ferr_cnt0 - f0), 64'd1);
    chk("abort_rx_done", 64'(rxd_cnt0 - r0), 64'd0);
    chk("abort_copi_data", 64'(cdo0), 64'h0);
    chk("abort_busy", 64'(busy_cnt0 - b0), 64'd0);

    // Wrap-around: header 3, 8 ones -> bits 3..0 and 31..28.
    cdi0 = 32'h12345678;
    r0 = rxd_cnt0; b0 = busy_cnt0;
    frame(0, {16'h0003, 8'hFF, 24'h0}, 24, 1'b1, rx);
    chk("wrap_copi_data", 64'(cdo0), 64'hF000000F);
    chk("wrap_rx_done", 64'(rxd_cnt0 - r0), 64'd1);
    chk("wrap_cipo", 64'(rx[47:24]), 64'h000181);
    chk("wrap_busy_seen", 64'(busy_cnt0 > b0), 64'h1);

    // Mode 0 full frame: header 31, 32 data bits.
    r0 = rxd_cnt0; f0 = ferr_cnt0;
    frame(0, {16'h001F, 32'hA5A50F0F}, 48, 1'b1, rx);
    chk("m0_copi_data", 64'(cdo0), 64'hA5A50F0F);
    chk("m0_cipo", 64'(rx), 64'h000F_12345678);
    chk("m0_rx_done", 64'(rxd_cnt0 - r0), 64'd1);
    chk("m0_frame_error", 64'(ferr_cnt0 - f0), 64'd0);
    chk("m0_busy_idle", 64'(busy0), 64'h0);

    // Mode 3 full frame with cipo_data changed mid-frame.
    cdi3 = 32'h12345678;
    r3 = rxd_cnt3;
    fork
      frame(3, {16'h001F, 32'hA5A50F0F}, 48, 1'b1, rx);
      begin
        wait_cyc(200);
        cdi3 = 32'hDEADBEEF;
      end
    join
    chk("m3_copi_data", 64'(cdo3), 64'hA5A50F0F);
    chk("m3_cipo", 64'(rx), 64'h000F_12345678);
    chk("m3_rx_done", 64'(rxd_cnt3 - r3), 64'd1);
    chk("m3_frame_error", 64'(ferr_cnt3), 64'd0);

    // Reset in the middle of XCHG with SS held low.
    cdi0 = 32'h0F0F0F0F;
    r0 = rxd_cnt0; f0 = ferr_cnt0;
    frame(0, {16'h001F, 8'hFF, 24'h0}, 24, 1'b0, rx);
    chk("xchg_busy", 64'(busy0), 64'h1);
    chk("xchg_partial", 64'(cdo0), 64'hFFA50F0F);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("mid_rst_copi_data", 64'(cdo0), 64'h0);
    chk("mid_rst_busy", 64'(busy0), 64'h0);
    chk("mid_rst_cipo", 64'(cipo0), 64'h0);
    chk("mid_rst_alarm", 64'(alarm0), 64'h0);
    rst_n = 1'b1;
    wait_cyc(2);

    // SCK activity with SS still low from before reset is ignored.
    for (int i = 0; i < 8; i++) begin
      pin_copi(0, 1'b1);
      pin_sck(0, 1'b1);
      wait_cyc(HALF);
      pin_sck(0, 1'b0);
      wait_cyc(HALF);
    end
    chk("post_rst_copi_data", 64'(cdo0), 64'h0);
    chk("post_rst_busy", 64'(busy_cnt0 > 0 ? busy0 : 1'b0), 64'h0);

    // SS must rise and fall again before a new frame is accepted.
    pin_ss(0, 1'b1);
    wait_cyc(2 * HALF);
    chk("post_rst_no_pulse", 64'((rxd_cnt0 - r0) + (ferr_cnt0 - f0)), 64'd0);
    frame(0, {16'h0007, 8'hC3, 24'h0}, 24, 1'b1, rx);
    chk("after_rst_copi_data", 64'(cdo0), 64'h000000C3);
    chk("after_rst_cipo", 64'(rx[47:24]), 64'h00030F);
    chk("after_rst_rx_done", 64'(rxd_cnt0 - r0), 64'd1);
    chk("after_rst_frame_error", 64'(ferr_cnt0 - f0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_peripheral_sync.md
# spi_peripheral_sync

Parametrised SPI peripheral (slave) that oversamples SCK/SS/COPI in the `sysclock` domain, so all state lives in one clock domain. It supports all four SPI modes and a power-of-two record size. Each frame carries a 16-bit bit-index header followed by full-duplex data exchange at decrementing bit indices with wrap-around. Coherent read snapshots, frame-done/error strobes and a link watchdog are provided. It sits between the board SPI pins and the user register record.

## Interface
- `SYSCLK_MHZ`, 27: sysclock frequency, MHz.
- `WDOG_TIMEOUT`, 2000: watchdog timeout, ms; 0 disables.
- `REC_BYTES`, 256: record size; power of two, 1..256. `REC_BITS = 8*REC_BYTES`, `IDX_W = clog2(REC_BITS)` (minimum 3).
- `CPOL`, 0: idle SCK level.
- `CPHA`, 0: 0 samples on the leading edge; 1 samples on the trailing edge.
- `sysclock`  in  1  system clock.
- `sysreset_n`  in  1  asynchronous, active-low reset.
- `device_clk`  in  1  SPI SCK (asynchronous).
- `device_ss`  in  1  SPI SS, active-low (asynchronous).
- `device_copi`  in  1  SPI COPI (asynchronous).
- `device_cipo`  out  1  SPI CIPO; high-Z while `device_ss`=1.
- `copi_data`  out  REC_BITS  user write record.
- `cipo_data`  in  REC_BITS  user read record.
- `busy`  out  1  high in XCHG.
- `rx_done`  out  1  1-cycle pulse at the end of a frame with ≥1 data bit.
- `frame_error`  out  1  1-cycle pulse when SS rises during HDR.
- `wdog_alarm`  out  1  no frame started within `WDOG_TIMEOUT` ms.

## Operation
- All three pins pass through 2-flop synchronizers, then edge detection. Sample edge: leading if `CPHA`=0, else trailing. Launch edge is the opposite edge. Leading edge is rising if `CPOL`=0.
- FSM states IDLE, HDR, XCHG.
  - IDLE→HDR on a detected SS falling edge. Same cycle: `cipo_data` is latched into `snap`, `hdr_cnt`=15, `idx`=0, cipo reg=0.
  - HDR: each sample edge shifts COPI MSB-first into the 16-bit header. After the 16th bit, `idx` = header[IDX_W-1:0] (upper bits ignored) and the FSM goes to XCHG.
  - XCHG: each sample edge writes `copi_data[idx]` = COPI and sets `idx` = `idx`-1. `idx` 0 wraps to REC_BITS-1.
  - Any state: a detected SS rise goes to IDLE. From XCHG with ≥1 data bit, pulse `rx_done`. From HDR (any header bits), pulse `frame_error`. XCHG with 0 bits gives no pulse.
- CIPO, set on each launch edge:
  - In HDR: the most recently sampled COPI bit (echo; 0 before the first sample).
  - In XCHG: `snap[idx]`.
  - CPHA=0: the first bit is the reset value 0, driven from SS assertion.
- SS-low at reset release is ignored: HDR needs a fresh falling edge.
- Watchdog:
  - Runs only while SS is high.
  - A ms prescaler counts `SYSCLK_MHZ*1000` cycles per ms; a ms counter is 16 bits and saturating.
  - `wdog_alarm` is set when ms count ≥ `WDOG_TIMEOUT` (and `WDOG_TIMEOUT` ≠ 0).
  - Prescaler, count and alarm all clear in the cycle SS is synchronized low.
- Reset values: FSM IDLE, `copi_data`=0, `snap`=0, cipo reg=0, `busy`=0, `rx_done`=0, `frame_error`=0, `wdog_alarm`=0, counters 0.

## Timing
- Pin-to-edge-detect latency: 2 sysclocks. `copi_data` bit visible 3 sysclocks after the pin sample edge.
- `device_cipo` changes within 3 sysclocks of the launch edge.
- Requirement: f_SCK ≤ f_sysclock/8; each SCK phase ≥ 4 sysclocks; SS setup/hold to SCK ≥ 4 sysclocks.
- `rx_done`/`frame_error` assert 3 sysclocks after the SS pin rises, for exactly 1 cycle.
- `busy` rises in the cycle after the 16th header sample; it falls together with the SS-rise detection.
- `snap` is coherent for the whole frame: `cipo_data` changes mid-frame are not transmitted.
- Simultaneous SS rise and SCK sample edge in one cycle: SS wins, the sample is discarded.

## Structure
- Shared package `spi_pkg`: FSM state encoding (IDLE/HDR/XCHG), `HDR_BITS`=16, mode/edge-select helper constants.
- One sub-module, `spi_sync_edge`: N-stage synchronizer plus rise/fall pulse outputs. It is instantiated three times (SCK, SS, COPI; COPI uses level only).
- Top level holds the FSM, record/snapshot registers, CIPO mux and watchdog.

## Test plan
- REC_BYTES=4, mode 0: header 31, data 0xA5A50F0F, `cipo_data`=0x12345678 → `copi_data`=0xA5A50F0F; CIPO shows header echo then 0x12345678 MSB-first; one `rx_done` pulse.
- Wrap: header 3, data 0xFF → `copi_data`=0xF000000F; `rx_done` pulses once.
- Mode 3 (CPOL=1, CPHA=1): repeat scenario 1 → identical results. Also change `cipo_data` mid-frame → the transmitted stream is still 0x12345678.
- SS rises after 10 header bits → one `frame_error` pulse, `copi_data` unchanged, `busy` never 1. Next full frame completes normally.
- Watchdog, SYSCLK_MHZ=1, WDOG_TIMEOUT=2, SS high from reset → `wdog_alarm`=1 after ~2000 sysclocks (±3). Driving SS low clears it within 3 cycles.
- `sysreset_n` low during XCHG (SS still low) → all outputs at reset values. Following SCK edges are ignored until SS rises and falls again.
